ofdm_symbol_scheduler: RTL and testbench

- Sequences QAM mapper output into the IFFT, one OFDM frame at a time.
- Issues one IFFT configuration word per frame, then assembles NUM_SYMBOLS symbols of 64 subcarriers each.
- Places data, pilot and null subcarriers in IFFT natural order and marks symbol boundaries with m_dlast.
- Sits between qam_mapper (upstream) and the IFFT core's data and config channels (downstream).

---
 rtl/ofdm_symbol_scheduler.sv | 158 +++++++++++++++
 tb/tb_ofdm_symbol_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_symbol_scheduler.sv
// rtl/ofdm_symbol_scheduler.sv - OFDM frame scheduler feeding QAM symbols into an IFFT
//
// Purpose: issues one IFFT config word per frame, then builds NUM_SYMBOLS
// symbols of 64 subcarriers in IFFT natural order. Data subcarriers take
// consecutive input words. Pilot and null subcarriers are generated locally.
//
// Ports:
//   aclk, reset_n            clock, asynchronous active-low reset
//   s_data_in/s_dvalid/s_dready   QAM symbols in (I[31:16], Q[15:0])
//   m_data_out/m_dvalid/m_dready  subcarrier samples out to IFFT
//   m_dlast                  set on subcarrier 63 of each symbol
//   m_subcarrier             subcarrier index of m_data_out
//   cfg_data/cfg_dvalid/cfg_dready  IFFT config channel
//   busy                     high whenever not IDLE
//   frame_done               pulse as the last beat of a frame is accepted
//   symbol_count             symbol currently being filled
module ofdm_symbol_scheduler #(
  parameter int          NUM_SYMBOLS = 4,
  parameter logic [15:0] PILOT_AMP   = 16'h5A82,
  parameter logic [7:0]  CFG_WORD    = 8'h00
) (
  input  logic        aclk,
  input  logic        reset_n,
  input  logic [31:0] s_data_in,
  input  logic        s_dvalid,
  output logic        s_dready,
  output logic [31:0] m_data_out,
  output logic        m_dvalid,
  input  logic        m_dready,
  output logic        m_dlast,
  output logic [5:0]  m_subcarrier,
  output logic [7:0]  cfg_data,
  output logic        cfg_dvalid,
  input  logic        cfg_dready,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  symbol_count
);

  typedef enum logic [1:0] {IDLE, CFG, FILL, DRAIN} state_t;

  localparam logic [15:0] PILOT_NEG = ~PILOT_AMP + 16'd1;
  localparam logic [7:0]  LAST_SYM  = 8'(NUM_SYMBOLS - 1);

  state_t      state_q, state_d;
  logic [5:0]  k_q, k_d;
  logic [7:0]  sym_q, sym_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic        last_q, last_d;
  logic [5:0]  sub_q, sub_d;

  logic        out_free;
  logic        k_is_data;
  logic        load;
  logic [31:0] beat;

  function automatic logic is_data(input logic [5:0] k);
    is_data = !((k == 6'd0) || ((k >= 6'd27) && (k <= 6'd37)) ||
                (k == 6'd7) || (k == 6'd21) || (k == 6'd43) || (k == 6'd57));
  endfunction

  // The output register can take a new beat when it is empty or its
  // current beat is leaving this cycle.
  assign out_free  = !valid_q || m_dready;
  assign k_is_data = is_data(k_q);
  // Pilots and nulls never wait for input; data carriers stall on s_dvalid.
  assign load      = (state_q == FILL) && out_free && (!k_is_data || s_dvalid);

  always_comb begin
    beat = 32'h0;
    if ((k_q == 6'd7) || (k_q == 6'd43) || (k_q == 6'd57)) begin
      beat = {PILOT_AMP, 16'h0000};
    end else if (k_q == 6'd21) begin
      beat = {PILOT_NEG, 16'h0000};
    end else if (k_is_data) begin
      beat = s_data_in;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    sym_d      = sym_q;
    valid_d    = valid_q;
    data_d     = data_q;
    last_d     = last_q;
    sub_d      = sub_q;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        // The word that wakes us is not consumed here.
        if (s_dvalid) state_d = CFG;
      end
      CFG: begin
        if (cfg_dready) begin
          state_d = FILL;
          k_d     = 6'd0;
          sym_d   = 8'd0;
        end
      end
      FILL: begin
        if (load) begin
          data_d  = beat;
          last_d  = (k_q == 6'd63);
          sub_d   = k_q;
          valid_d = 1'b1;
          k_d     = k_q + 6'd1;
          if (k_q == 6'd63) begin
            if (sym_q < LAST_SYM) sym_d = sym_q + 8'd1;
            else                  state_d = DRAIN;
          end
        end else if (valid_q && m_dready) begin
          valid_d = 1'b0;
        end
      end
      DRAIN: begin
        if (valid_q && m_dready) begin
          valid_d    = 1'b0;
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      k_q     <= 6'd0;
      sym_q   <= 8'd0;
      valid_q <= 1'b0;
      data_q  <= 32'h0;
      last_q  <= 1'b0;
      sub_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      sym_q   <= sym_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      sub_q   <= sub_d;
    end
  end

  assign s_dready     = (state_q == FILL) && k_is_data && out_free;
  assign m_data_out   = data_q;
  assign m_dvalid     = valid_q;
  assign m_dlast      = last_q;
  assign m_subcarrier = sub_q;
  assign cfg_dvalid   = (state_q == CFG);
  assign cfg_data     = (state_q == CFG) ? CFG_WORD : 8'h00;
  assign busy         = (state_q != IDLE);
  assign symbol_count = sym_q;

endmodule

// File: tb/tb_ofdm_symbol_scheduler.sv
// tb/tb_ofdm_symbol_scheduler.sv - directed self-checking bench for ofdm_symbol_scheduler
module tb_ofdm_symbol_scheduler;

  logic        aclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] s_data_in = 32'h0;
  logic        s_dvalid = 1'b0;
  logic        s_dready;
  logic [31:0] m_data_out;
  logic        m_dvalid;
  logic        m_dready = 1'b1;
  logic        m_dlast;
  logic [5:0]  m_subcarrier;
  logic [7:0]  cfg_data;
  logic        cfg_dvalid;
  logic        cfg_dready = 1'b1;
  logic        busy;
  logic        frame_done;
  logic [7:0]  symbol_count;

  ofdm_symbol_scheduler dut (
    .aclk(aclk), .reset_n(reset_n),
    .s_data_in(s_data_in), .s_dvalid(s_dvalid), .s_dready(s_dready),
    .m_data_out(m_data_out), .m_dvalid(m_dvalid), .m_dready(m_dready),
    .m_dlast(m_dlast), .m_subcarrier(m_subcarrier),
    .cfg_data(cfg_data), .cfg_dvalid(cfg_dvalid), .cfg_dready(cfg_dready),
    .busy(busy), .frame_done(frame_done), .symbol_count(symbol_count)
  );

  always #5 aclk = ~aclk;

  logic [62:0] outs;
  assign outs = {m_data_out, m_dvalid, m_dlast, m_subcarrier, cfg_data, cfg_dvalid,
                 busy, frame_done, symbol_count, s_dready};

  int errors = 0;
  int checks = 0;

  // stimulus controls (written by the initial block only)
  logic feed_en = 1'b1;
  int   feed_limit = 192;
  logic bp_en = 1'b0;
  logic stall_arm = 1'b0;

  // driver state
  int   stall_left = 0;
  logic stall_done = 1'b0;

  // monitor state
  int          in_count = 0;
  int          bc = 0;
  int          cfg_count = 0;
  logic [7:0]  cfg_last = 8'hFF;
  int          fd_count = 0;
  int          stab_err = 0;
  int          stall_idle = 0;
  logic [31:0] bdata [0:2047];
  logic [5:0]  bsub  [0:2047];
  logic        blast [0:2047];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = 32'h0;
  logic [5:0]  prev_sub = 6'd0;
  logic        prev_last = 1'b0;

  always @(negedge aclk) begin
    if (stall_left > 0) stall_left = stall_left - 1;
    if (stall_arm && !stall_done && m_dvalid && m_subcarrier == 6'd21) begin
      stall_left = 5;
      stall_done = 1'b1;
    end
    s_dvalid  = feed_en && (in_count < feed_limit) && (stall_left == 0);
    s_data_in = {in_count[15:0] + 16'd1, in_count[15:0] + 16'd1};
    m_dready  = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  always @(posedge aclk) begin
    if (m_dvalid && m_dready && bc < 2048) begin
      bdata[bc] <= m_data_out;
      bsub[bc]  <= m_subcarrier;
      blast[bc] <= m_dlast;
      bc        <= bc + 1;
    end
    if (s_dvalid && s_dready) in_count <= in_count + 1;
    if (cfg_dvalid && cfg_dready) begin
      cfg_count <= cfg_count + 1;
      cfg_last  <= cfg_data;
    end
    if (frame_done) fd_count <= fd_count + 1;
    if (prev_stall && (m_dvalid !== 1'b1 || m_data_out !== prev_data ||
                       m_subcarrier !== prev_sub || m_dlast !== prev_last))
      stab_err <= stab_err + 1;
    prev_stall <= m_dvalid && !m_dready;
    prev_data  <= m_data_out;
    prev_sub   <= m_subcarrier;
    prev_last  <= m_dlast;
    if (stall_left > 0 && !m_dvalid) stall_idle <= stall_idle + 1;
  end

  function automatic logic [31:0] exp_word(int k, int n);
    if (k == 7 || k == 43 || k == 57) return 32'h5A820000;
    if (k == 21) return 32'hA57E0000;
    if (k == 0 || (k >= 27 && k <= 37)) return 32'h00000000;
    return {n[15:0], n[15:0]};
  endfunction

  // Compare one recorded frame (256 beats from bbase) against the map, with
  // data words numbered from wbase+1.
  function automatic int frame_mismatches(int bbase, int wbase);
    int bad = 0;
    int n = wbase;
    for (int b = 0; b < 256; b++) begin
      int k = b % 64;
      logic is_d;
      is_d = !(k == 0 || (k >= 27 && k <= 37) || k == 7 || k == 21 || k == 43 || k == 57);
      if (is_d) n++;
      if (bdata[bbase + b] !== exp_word(k, n)) bad++;
      if (bsub[bbase + b] !== 6'(k)) bad++;
      if (blast[bbase + b] !== (k == 63)) bad++;
    end
    return bad;
  endfunction

  initial begin
    int b0, w0, mm, t;

    // ---- reset held with s_dvalid high
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      checks++;
      assert (outs === 63'h0) else begin
        errors++; $error("FAIL reset_outs cycle %0d: got %h want 0", i, outs);
      end
    end
    @(negedge aclk);
    reset_n = 1'b1;

    // ---- full frame, no backpressure
    b0 = bc; w0 = in_count;
    t = 0;
    while (fd_count < 1 && t < 3000) begin @(negedge aclk); t++; end
    repeat (3) @(negedge aclk);
    checks++;
    assert (fd_count === 1) else begin errors++; $error("FAIL frame1_done got %0d want 1", fd_count); end
    checks++;
    assert (cfg_count === 1 && cfg_last === 8'h00) else begin
      errors++; $error("FAIL frame1_cfg got count=%0d val=%h want 1/00", cfg_count, cfg_last);
    end
    checks++;
    assert (bc - b0 === 256) else begin errors++; $error("FAIL frame1_beats got %0d want 256", bc - b0); end
    checks++;
    assert (in_count - w0 === 192) else begin errors++; $error("FAIL frame1_inputs got %0d want 192", in_count - w0); end
    mm = frame_mismatches(b0, w0);
    checks++;
    assert (mm === 0) else begin errors++; $error("FAIL frame1_map got %0d bad want 0", mm); end
    checks++;
    assert (bdata[b0 + 1] === 32'h00010001 && bdata[b0 + 8] === 32'h00070007) else begin
      errors++; $error("FAIL frame1_words got %h %h want 00010001 00070007", bdata[b0 + 1], bdata[b0 + 8]);
    end
    checks++;
    assert (blast[b0 + 63] === 1'b1 && blast[b0 + 127] === 1'b1 && blast[b0 + 191] === 1'b1 &&
            blast[b0 + 255] === 1'b1 && blast[b0 + 62] === 1'b0) else begin
      errors++; $error("FAIL frame1_last got %b%b%b%b%b want 11110", blast[b0 + 63], blast[b0 + 127],
                       blast[b0 + 191], blast[b0 + 255], blast[b0 + 62]);
    end
    checks++;
    assert (bdata[b0 + 128 + 21] === 32'hA57E0000 && bdata[b0 + 192 + 57] === 32'h5A820000 &&
            bdata[b0 + 64 + 32] === 32'h0) else begin
      errors++; $error("FAIL frame1_pilots got %h %h %h want A57E0000 5A820000 0",
                       bdata[b0 + 149], bdata[b0 + 249], bdata[b0 + 96]);
    end
    checks++;
    assert (busy === 1'b0 && m_dvalid === 1'b0) else begin
      errors++; $error("FAIL frame1_idle got busy=%b valid=%b want 0/0", busy, m_dvalid);
    end

    // ---- backpressure frame
    b0 = bc; w0 = in_count;
    bp_en = 1'b1;
    feed_limit = 384;
    t = 0;
    while (fd_count < 2 && t < 6000) begin @(negedge aclk); t++; end
    bp_en = 1'b0;
    repeat (3) @(negedge aclk);
    mm = frame_mismatches(b0, w0);
    checks++;
    assert (fd_count === 2 && bc - b0 === 256 && mm === 0) else begin
      errors++; $error("FAIL bp_frame got done=%0d beats=%0d bad=%0d want 2/256/0", fd_count, bc - b0, mm);
    end
    checks++;
    assert (stab_err === 0) else begin errors++; $error("FAIL bp_stable got %0d want 0", stab_err); end
    checks++;
    assert (in_count === 384) else begin errors++; $error("FAIL bp_inputs got %0d want 384", in_count); end

    // ---- underflow at k=22 of symbol 0
    b0 = bc; w0 = in_count;
    stall_arm = 1'b1;
    feed_limit = 576;
    t = 0;
    while (fd_count < 3 && t < 3000) begin @(negedge aclk); t++; end
    repeat (3) @(negedge aclk);
    mm = frame_mismatches(b0, w0);
    checks++;
    assert (fd_count === 3 && bc - b0 === 256 && mm === 0) else begin
      errors++; $error("FAIL uf_frame got done=%0d beats=%0d bad=%0d want 3/256/0", fd_count, bc - b0, mm);
    end
    checks++;
    assert (stall_idle === 4) else begin errors++; $error("FAIL uf_gap got %0d idle want 4", stall_idle); end
    checks++;
    assert (bdata[b0 + 22] === {16'd404, 16'd404}) else begin
      errors++; $error("FAIL uf_k22 got %h want %h", bdata[b0 + 22], {16'd404, 16'd404});
    end

    // ---- config stall
    cfg_dready = 1'b0;
    feed_limit = 100000;
    repeat (2) @(negedge aclk);
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      checks++;
      assert (s_dready === 1'b0 && m_dvalid === 1'b0 && cfg_dvalid === 1'b1) else begin
        errors++; $error("FAIL cfg_stall cycle %0d got rdy=%b vld=%b cfgv=%b want 0/0/1",
                         i, s_dready, m_dvalid, cfg_dvalid);
      end
    end
    cfg_dready = 1'b1;

    // ---- reset mid-frame at k=30 of symbol 2
    t = 0;
    while (!(m_dvalid && symbol_count == 8'd2 && m_subcarrier == 6'd30) && t < 2000) begin
      @(negedge aclk); t++;
    end
    checks++;
    assert (t < 2000) else begin errors++; $error("FAIL rst_reach got timeout want k30 sym2"); end
    reset_n = 1'b0;
    #1;
    checks++;
    assert (outs === 63'h0) else begin errors++; $error("FAIL rst_mid got %h want 0", outs); end
    @(negedge aclk);
    @(negedge aclk);
    reset_n = 1'b1;
    w0 = cfg_count;
    t = 0;
    while (cfg_count == w0 && t < 50) begin @(negedge aclk); t++; end
    checks++;
    assert (cfg_count === w0 + 1) else begin
      errors++; $error("FAIL rst_cfg got %0d cfg beats want %0d", cfg_count - w0, 1);
    end
    t = 0;
    while (!m_dvalid && t < 50) begin @(negedge aclk); t++; end
    checks++;
    assert (m_dvalid === 1'b1 && m_subcarrier === 6'd0 && symbol_count === 8'd0 &&
            m_data_out === 32'h0) else begin
      errors++; $error("FAIL rst_restart got v=%b k=%0d sym=%0d d=%h want 1/0/0/0",
                       m_dvalid, m_subcarrier, symbol_count, m_data_out);
    end

    feed_en = 1'b0;
    repeat (2) @(negedge aclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
